sevenseg_multi_display: RTL

Parametrised multi-digit seven-segment driver for the game's timers and score readouts. It converts a binary value to BCD over several cycles using a shift-and-add-3 loop. It drives NUM_DIGITS static digits and supports leading-zero blanking, overflow indication (dashes) and a blink mode for "time expired" alerts. It sits between game-logic counters and the board's HEX outputs, and replaces single-digit per-module decoders.

---
 rtl/sevenseg_pkg.sv | 31 +++
 rtl/sevenseg_bin2bcd.sv | 73 +++++++
 rtl/sevenseg_multi_display.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the multi-digit seven-segment driver.
// Glyphs are stored active-low with bit 0 = segment a, bit 6 = segment g.
// seg_pol() converts a stored glyph to the board polarity.
// state_t is the driver FSM state encoding.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_UPDATE
  } state_t;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_pol(input logic [6:0] glyph, input bit active_low);
    return active_low ? glyph : ~glyph;
  endfunction

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/sevenseg_bin2bcd.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_start   : capture i_value and begin conversion (ignored semantics left to caller)
//   i_value   : binary input, VALUE_W bits
//   o_busy    : conversion in progress
//   o_done    : high during the cycle whose clock edge performs the final shift;
//               o_bcd holds the finished result from the following cycle
//   o_bcd     : BCD accumulator, 4*NUM_DIGITS bits, digit 0 in bits [3:0]
module sevenseg_bin2bcd
  import sevenseg_pkg::*;
#(
  parameter int unsigned VALUE_W    = 7,
  parameter int unsigned NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [VALUE_W-1:0]      i_value,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*NUM_DIGITS-1:0] o_bcd
);

  localparam int unsigned CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;

  logic [VALUE_W-1:0]      r_bin;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_busy;
  logic [4*NUM_DIGITS-1:0] w_adj;
  logic [3:0]              w_nib;
  logic                    w_last;

  always_comb begin
    w_adj = '0;
    w_nib = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      w_nib = r_bcd[4*i +: 4];
      w_adj[4*i +: 4] = (w_nib >= 4'd5) ? w_nib + 4'd3 : w_nib;
    end
  end

  assign w_last = r_busy && (r_cnt == CNT_W'(VALUE_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_bin  <= i_value;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bcd <= {w_adj[4*NUM_DIGITS-2:0], r_bin[VALUE_W-1]};
      r_bin <= r_bin << 1;
      if (w_last) begin
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = w_last;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/sevenseg_multi_display.sv
// Multi-digit seven-segment driver: converts a binary value to BCD over
// VALUE_W cycles, then registers a glyph pattern with optional leading-zero
// blanking and dash display on overflow. Whole display can blink.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   value_i         : binary value, sampled when a load is accepted
//   load_i          : convert/display request, accepted only when idle
//   blank_zeros_i   : blank leading zero digits, sampled with value_i
//   blink_i         : live blink enable
//   busy_o          : conversion in progress
//   overflow_o      : last accepted value was >= 10^NUM_DIGITS
//   segments_o      : digit k in bits [7k+6:7k], digit 0 = units, bit 0 = seg a
module sevenseg_multi_display
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned VALUE_W      = 7,
  parameter int unsigned BLINK_CYCLES = 25_000_000,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VALUE_W-1:0]      value_i,
  input  logic                    load_i,
  input  logic                    blank_zeros_i,
  input  logic                    blink_i,
  output logic                    busy_o,
  output logic                    overflow_o,
  output logic [7*NUM_DIGITS-1:0] segments_o
);

  localparam bit          POL_LOW   = (ACTIVE_LOW != 0);
  localparam int unsigned OVF_LIMIT = pow10(NUM_DIGITS);
  localparam int unsigned BW        = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [6:0]  OFF_GLYPH = seg_pol(SEG_BLANK, POL_LOW);

  state_t r_state;
  state_t w_next;

  logic                    w_start;
  logic                    w_conv_busy;
  logic                    w_conv_done;
  logic [4*NUM_DIGITS-1:0] w_bcd;

  logic                    r_bz;
  logic                    r_ovf_cap;
  logic                    r_ovf;
  logic [7*NUM_DIGITS-1:0] r_pattern;
  logic [7*NUM_DIGITS-1:0] w_pattern;
  logic [3:0]              w_nib;
  logic [6:0]              w_glyph;
  logic                    w_hi_zero;

  logic [BW-1:0]           r_blink_cnt;
  logic                    r_phase_on;

  assign w_start = (r_state == S_IDLE) && load_i;

  sevenseg_bin2bcd #(
    .VALUE_W   (VALUE_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_start),
    .i_value(value_i),
    .o_busy (w_conv_busy),
    .o_done (w_conv_done),
    .o_bcd  (w_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (load_i) w_next = S_CONVERT;
      // The converter flags its final shift, so UPDATE starts exactly when
      // the BCD result becomes valid.
      S_CONVERT: if (w_conv_done || !w_conv_busy) w_next = S_UPDATE;
      S_UPDATE:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  assign busy_o = (r_state != S_IDLE);

  // Walk from the most significant digit down so "all higher digits are
  // zero" is known when each digit is decided; digit 0 is never blanked.
  always_comb begin
    w_pattern = '0;
    w_nib     = '0;
    w_glyph   = SEG_BLANK;
    w_hi_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      w_nib = w_bcd[4*(NUM_DIGITS-1-i) +: 4];
      if (r_ovf_cap)
        w_glyph = SEG_DASH;
      else if (r_bz && w_hi_zero && (w_nib == 4'd0) && (i != NUM_DIGITS - 1))
        w_glyph = SEG_BLANK;
      else if (w_nib <= 4'd9)
        w_glyph = SEG_DIGIT[w_nib];
      else
        w_glyph = SEG_BLANK;
      w_hi_zero = w_hi_zero && (w_nib == 4'd0);
      w_pattern[7*(NUM_DIGITS-1-i) +: 7] = seg_pol(w_glyph, POL_LOW);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bz      <= 1'b0;
      r_ovf_cap <= 1'b0;
      r_ovf     <= 1'b0;
      r_pattern <= {NUM_DIGITS{OFF_GLYPH}};
    end else begin
      if (w_start) begin
        r_bz      <= blank_zeros_i;
        r_ovf_cap <= (32'(value_i) >= OVF_LIMIT);
      end
      if (r_state == S_UPDATE) begin
        r_pattern <= w_pattern;
        r_ovf     <= r_ovf_cap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !blink_i) begin
      r_blink_cnt <= '0;
      r_phase_on  <= 1'b1;
    end else if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      r_blink_cnt <= '0;
      r_phase_on  <= ~r_phase_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign overflow_o = r_ovf;
  assign segments_o = (!blink_i || r_phase_on) ? r_pattern : {NUM_DIGITS{OFF_GLYPH}};

endmodule
